// File: rtl/oven_cook_controller.sv
// Oven cook sequencer: BCD time entry, start/pause/resume/cancel, and a
// one-second BCD countdown that ends in DONE.
module oven_cook_controller #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in,
    input  logic       pushButton,
    input  logic       onOff,
    output logic [3:0] minuteCountVal2,
    output logic [3:0] minuteCountVal1,
    output logic [3:0] secondCountVal2,
    output logic [3:0] secondCountVal1,
    output logic       heaterOn,
    output logic       done,
    output logic [1:0] state
);
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COOK  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_push_prev;
    logic          r_onoff_prev;
    logic [3:0]    r_m2, r_m1, r_s2, r_s1;
    logic [3:0]    w_m2_nxt, w_m1_nxt, w_s2_nxt, w_s1_nxt;
    logic [3:0]    w_dec_m2, w_dec_m1, w_dec_s2, w_dec_s1;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          w_push_rise;
    logic          w_onoff_rise;
    logic          w_time_zero;
    logic          w_dec_zero;
    logic          w_tick;

    assign w_push_rise  = pushButton & ~r_push_prev;
    assign w_onoff_rise = onOff & ~r_onoff_prev;
    assign w_time_zero  = ({r_m2, r_m1, r_s2, r_s1} == 16'h0000);
    assign w_tick       = (r_presc == TICK_LAST);

    // BCD borrow chain; seconds refill to 59 even if S2 was entered above 5.
    always_comb begin
        w_dec_m2 = r_m2;
        w_dec_m1 = r_m1;
        w_dec_s2 = r_s2;
        w_dec_s1 = r_s1;
        if (r_s1 != 4'd0) begin
            w_dec_s1 = r_s1 - 4'd1;
        end else if (r_s2 != 4'd0) begin
            w_dec_s2 = r_s2 - 4'd1;
            w_dec_s1 = 4'd9;
        end else if (r_m1 != 4'd0) begin
            w_dec_m1 = r_m1 - 4'd1;
            w_dec_s2 = 4'd5;
            w_dec_s1 = 4'd9;
        end else if (r_m2 != 4'd0) begin
            w_dec_m2 = r_m2 - 4'd1;
            w_dec_m1 = 4'd9;
            w_dec_s2 = 4'd5;
            w_dec_s1 = 4'd9;
        end
    end

    assign w_dec_zero = ({w_dec_m2, w_dec_m1, w_dec_s2, w_dec_s1} == 16'h0000);

    always_comb begin
        w_state_nxt = r_state;
        w_m2_nxt    = r_m2;
        w_m1_nxt    = r_m1;
        w_s2_nxt    = r_s2;
        w_s1_nxt    = r_s1;
        w_presc_nxt = r_presc;
        case (r_state)
            S_IDLE: begin
                // onOff takes priority; a simultaneous pushButton rise is dropped.
                if (w_onoff_rise) begin
                    if (!w_time_zero) begin
                        w_state_nxt = S_COOK;
                        w_presc_nxt = PRESC_ZERO;
                    end
                end else if (w_push_rise && (in <= 4'd9)) begin
                    w_m2_nxt = r_m1;
                    w_m1_nxt = r_s2;
                    w_s2_nxt = r_s1;
                    w_s1_nxt = in;
                end
            end
            S_COOK: begin
                if (w_onoff_rise) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_tick) begin
                    w_presc_nxt = PRESC_ZERO;
                    w_m2_nxt    = w_dec_m2;
                    w_m1_nxt    = w_dec_m1;
                    w_s2_nxt    = w_dec_s2;
                    w_s1_nxt    = w_dec_s1;
                    if (w_dec_zero) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_presc_nxt = r_presc + PRESC_ONE;
                end
            end
            S_PAUSE: begin
                if (w_onoff_rise) begin
                    w_state_nxt = S_COOK;
                    w_presc_nxt = PRESC_ZERO;
                end else if (w_push_rise) begin
                    w_state_nxt = S_IDLE;
                    w_m2_nxt    = 4'd0;
                    w_m1_nxt    = 4'd0;
                    w_s2_nxt    = 4'd0;
                    w_s1_nxt    = 4'd0;
                end
            end
            S_DONE: begin
                if (w_onoff_rise || w_push_rise) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_push_prev  <= 1'b0;
            r_onoff_prev <= 1'b0;
            r_m2         <= 4'd0;
            r_m1         <= 4'd0;
            r_s2         <= 4'd0;
            r_s1         <= 4'd0;
            r_presc      <= PRESC_ZERO;
        end else begin
            r_push_prev  <= pushButton;
            r_onoff_prev <= onOff;
            r_m2         <= w_m2_nxt;
            r_m1         <= w_m1_nxt;
            r_s2         <= w_s2_nxt;
            r_s1         <= w_s1_nxt;
            r_presc      <= w_presc_nxt;
        end
    end

    assign minuteCountVal2 = r_m2;
    assign minuteCountVal1 = r_m1;
    assign secondCountVal2 = r_s2;
    assign secondCountVal1 = r_s1;
    assign heaterOn        = (r_state == S_COOK);
    assign done            = (r_state == S_DONE);
    assign state           = r_state;

endmodule

// File: tb/tb_oven_cook_controller.sv
// Bench for oven_cook_controller with TICK_DIV=4: expected snapshots
// {state, heaterOn, done, M2 M1 S2 S1} are queued and popped after each edge.
module tb_oven_cook_controller;
    logic       clk;
    logic       reset;
    logic [3:0] in;
    logic       pushButton;
    logic       onOff;
    logic [3:0] minuteCountVal2, minuteCountVal1, secondCountVal2, secondCountVal1;
    logic       heaterOn;
    logic       done;
    logic [1:0] state;

    logic [19:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    wire  [19:0] w_snap = {state, heaterOn, done, minuteCountVal2, minuteCountVal1,
                           secondCountVal2, secondCountVal1};

    oven_cook_controller #(.TICK_DIV(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .in             (in),
        .pushButton     (pushButton),
        .onOff          (onOff),
        .minuteCountVal2(minuteCountVal2),
        .minuteCountVal1(minuteCountVal1),
        .secondCountVal2(secondCountVal2),
        .secondCountVal1(secondCountVal1),
        .heaterOn       (heaterOn),
        .done           (done),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [19:0] pk(input logic [1:0] st, input logic [15:0] t);
        return {st, st == 2'd1, st == 2'd3, t};
    endfunction

    // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
    task automatic drive_edge(input logic pb, input logic oo, input logic [3:0] d);
        pushButton = pb;
        onOff      = oo;
        in         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_edge(1'b0, 1'b0, 4'd0);
        reset = 1'b0;
    endtask

    task automatic enter_digit(input logic [3:0] d);
        drive_edge(1'b1, 1'b0, d);
        drive_edge(1'b0, 1'b0, d);
    endtask

    task automatic test_reset();
        logic [19:0] e;
        reset = 1'b1;
        drive_edge(1'b1, 1'b1, 4'd5);
        drive_edge(1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        exp_q.push_back(pk(2'd0, 16'h0000));
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL reset: got %h want %h", w_snap, e);
        end
    endtask

    task automatic test_entry();
        logic [19:0] e;
        logic [3:0]  digs[4] = '{4'd1, 4'd2, 4'd13, 4'd5};
        logic [15:0] tv[4]   = '{16'h0001, 16'h0012, 16'h0012, 16'h0125};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pk(2'd0, tv[i]));
            enter_digit(digs[i]);
            e = exp_q.pop_front(); n_cmp++;
            if (w_snap !== e) begin
                n_err++; $display("FAIL entry_%0d: got %h want %h", i, w_snap, e);
            end
        end
        // Held button shifts exactly once.
        exp_q.push_back(pk(2'd0, 16'h1257));
        for (int i = 0; i < 3; i++) drive_edge(1'b1, 1'b0, 4'd7);
        drive_edge(1'b0, 1'b0, 4'd7);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL entry_hold: got %h want %h", w_snap, e);
        end
    endtask

    task automatic test_cook_done();
        logic [19:0] e;
        do_reset();
        enter_digit(4'd2);
        exp_q.push_back(pk(2'd1, 16'h0002));
        drive_edge(1'b0, 1'b1, 4'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL cook_start: got %h want %h", w_snap, e);
        end
        for (int i = 1; i <= 8; i++) begin
            if (i < 4)      exp_q.push_back(pk(2'd1, 16'h0002));
            else if (i < 8) exp_q.push_back(pk(2'd1, 16'h0001));
            else            exp_q.push_back(pk(2'd3, 16'h0000));
            drive_edge(1'b0, 1'b0, 4'd0);
            e = exp_q.pop_front(); n_cmp++;
            if (w_snap !== e) begin
                n_err++; $display("FAIL cook_edge%0d: got %h want %h", i, w_snap, e);
            end
        end
        exp_q.push_back(pk(2'd0, 16'h0000));
        enter_digit(4'd9);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL done_push_exit: got %h want %h", w_snap, e);
        end
    endtask

    task automatic test_borrow();
        logic [19:0] e;
        logic [15:0] ent[3]  = '{16'h0100, 16'h1000, 16'h0099};
        logic [15:0] dec1[3] = '{16'h0059, 16'h0959, 16'h0098};
        for (int c = 0; c < 3; c++) begin
            do_reset();
            for (int j = 0; j < 4; j++) enter_digit(ent[c][4*(3-j) +: 4]);
            drive_edge(1'b0, 1'b1, 4'd0);
            for (int k = 0; k < 3; k++) drive_edge(1'b0, 1'b0, 4'd0);
            exp_q.push_back(pk(2'd1, ent[c]));
            e = exp_q.pop_front(); n_cmp++;
            if (w_snap !== e) begin
                n_err++; $display("FAIL borrow_pre_%0d: got %h want %h", c, w_snap, e);
            end
            exp_q.push_back(pk(2'd1, dec1[c]));
            drive_edge(1'b0, 1'b0, 4'd0);
            e = exp_q.pop_front(); n_cmp++;
            if (w_snap !== e) begin
                n_err++; $display("FAIL borrow_tick_%0d: got %h want %h", c, w_snap, e);
            end
        end
    endtask

    task automatic test_pause();
        logic [19:0] e;
        do_reset();
        enter_digit(4'd5);
        drive_edge(1'b0, 1'b1, 4'd0);
        drive_edge(1'b0, 1'b0, 4'd0);
        drive_edge(1'b1, 1'b0, 4'd7);
        exp_q.push_back(pk(2'd1, 16'h0005));
        drive_edge(1'b0, 1'b0, 4'd7);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL cook_ignores_push: got %h want %h", w_snap, e);
        end
        // Pause lands on the tick edge; the tick must be discarded.
        exp_q.push_back(pk(2'd2, 16'h0005));
        drive_edge(1'b0, 1'b1, 4'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL pause_on_tick: got %h want %h", w_snap, e);
        end
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(pk(2'd2, 16'h0005));
            drive_edge(1'b0, 1'b0, 4'd0);
            e = exp_q.pop_front(); n_cmp++;
            if (w_snap !== e) begin
                n_err++; $display("FAIL pause_hold_%0d: got %h want %h", i, w_snap, e);
            end
        end
        drive_edge(1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) drive_edge(1'b0, 1'b0, 4'd0);
        exp_q.push_back(pk(2'd1, 16'h0005));
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL resume_pre: got %h want %h", w_snap, e);
        end
        exp_q.push_back(pk(2'd1, 16'h0004));
        drive_edge(1'b0, 1'b0, 4'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL resume_tick: got %h want %h", w_snap, e);
        end
        exp_q.push_back(pk(2'd2, 16'h0004));
        drive_edge(1'b0, 1'b1, 4'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL repause: got %h want %h", w_snap, e);
        end
        exp_q.push_back(pk(2'd0, 16'h0000));
        drive_edge(1'b1, 1'b0, 4'd3);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL cancel: got %h want %h", w_snap, e);
        end
        drive_edge(1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_zero_and_both();
        logic [19:0] e;
        do_reset();
        exp_q.push_back(pk(2'd0, 16'h0000));
        drive_edge(1'b0, 1'b1, 4'd0);
        drive_edge(1'b0, 1'b0, 4'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL zero_start: got %h want %h", w_snap, e);
        end
        enter_digit(4'd3);
        exp_q.push_back(pk(2'd1, 16'h0003));
        drive_edge(1'b1, 1'b1, 4'd8);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL both_rise: got %h want %h", w_snap, e);
        end
        drive_edge(1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_reset_mid();
        logic [19:0] e;
        do_reset();
        enter_digit(4'd7);
        drive_edge(1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) drive_edge(1'b0, 1'b0, 4'd0);
        exp_q.push_back(pk(2'd1, 16'h0007));
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL reset_mid_pre: got %h want %h", w_snap, e);
        end
        // Reset lands on what would be the tick edge.
        reset = 1'b1;
        exp_q.push_back(pk(2'd0, 16'h0000));
        drive_edge(1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL reset_mid: got %h want %h", w_snap, e);
        end
        exp_q.push_back(pk(2'd0, 16'h0000));
        for (int i = 0; i < 5; i++) drive_edge(1'b0, 1'b0, 4'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL reset_mid_after: got %h want %h", w_snap, e);
        end
    endtask

    task automatic test_done_onoff_exit();
        logic [19:0] e;
        do_reset();
        enter_digit(4'd1);
        drive_edge(1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) drive_edge(1'b0, 1'b0, 4'd0);
        exp_q.push_back(pk(2'd3, 16'h0000));
        drive_edge(1'b0, 1'b0, 4'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL done_reach: got %h want %h", w_snap, e);
        end
        exp_q.push_back(pk(2'd3, 16'h0000));
        for (int i = 0; i < 6; i++) drive_edge(1'b0, 1'b0, 4'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL done_hold: got %h want %h", w_snap, e);
        end
        exp_q.push_back(pk(2'd0, 16'h0000));
        drive_edge(1'b0, 1'b1, 4'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (w_snap !== e) begin
            n_err++; $display("FAIL done_onoff_exit: got %h want %h", w_snap, e);
        end
        drive_edge(1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        in         = 4'd0;
        pushButton = 1'b0;
        onOff      = 1'b0;
        test_reset();
        test_entry();
        test_cook_done();
        test_borrow();
        test_pause();
        test_zero_and_both();
        test_reset_mid();
        test_done_onoff_exit();
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL queue_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oven_cook_controller.md
# oven_cook_controller

Sequencing controller for the oven simulator: collects a cook time as BCD digits from the switch inputs and push button, starts, pauses, resumes and cancels the cook cycle, and counts the time down once per second. Its four BCD digit outputs feed the sevenSeg display instances. heaterOn and done drive the oven status indicators. It sits beside ovenClock and shares the board clock and switch inputs with it.

## Interface
- TICK_DIV, 50000000, number of clk cycles per one-second countdown tick (≥2; benches use 4)
- clk  input  1  board clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- in  input  4  BCD digit to enter (values 10–15 are ignored)
- pushButton  input  1  digit-enter / cancel button; level, already debounced and synchronous to clk
- onOff  input  1  start / pause / resume / acknowledge button; level, already debounced and synchronous to clk
- minuteCountVal2  output  4  minutes tens digit (BCD)
- minuteCountVal1  output  4  minutes units digit (BCD)
- secondCountVal2  output  4  seconds tens digit (BCD)
- secondCountVal1  output  4  seconds units digit (BCD)
- heaterOn  output  1  high only in COOK
- done  output  1  high only in DONE
- state  output  2  IDLE=0, COOK=1, PAUSE=2, DONE=3

## Operation
- Edge detect: each button has a registered previous-value flop. rise = level & ~prev. Holding a button gives exactly one rise.
- Priority when both buttons rise in the same cycle: onOff wins and the pushButton rise is discarded.
- IDLE:
  - pushButton rise with in ≤ 9: the digits shift left. M2←M1, M1←S2, S2←S1, S1←in.
  - pushButton rise with in > 9: no change.
  - onOff rise with time ≠ 00:00: go to COOK and clear the prescaler.
  - onOff rise with time = 00:00: stay in IDLE.
- COOK:
  - The prescaler counts 0..TICK_DIV-1. The tick is the cycle where it equals TICK_DIV-1; the prescaler then wraps to 0.
  - On tick, decrement the time in BCD:
    - S1>0: S1−1.
    - else S2>0: S2−1, S1=9.
    - else (seconds = 00) M1>0: M1−1, S=59.
    - else M2>0: M2−1, M1=9, S=59.
  - Entered seconds above 59 (e.g. 99) count down normally, 99→98…→00, then borrow.
  - If a decrement yields 00:00, go to DONE on the same edge.
  - onOff rise: go to PAUSE. A tick coinciding with that rise is not applied.
  - pushButton is ignored.
- PAUSE:
  - Time and prescaler are frozen.
  - onOff rise: go to COOK and clear the prescaler.
  - pushButton rise: time ← 00:00, go to IDLE (cancel).
- DONE:
  - Time holds 00:00.
  - A rise on either button goes to IDLE. Digits are not modified on that edge.
- Width rules: digits always hold 0–9, except S2, which may hold 0–9 from entry. The prescaler is ceil(log2(TICK_DIV)) bits.

## Timing
- Reset (synchronous, dominant over all other inputs): state=IDLE, all digits=0, prescaler=0, edge flops=0, heaterOn=0, done=0.
- Button response: a level first sampled high at edge k (low at k−1) acts at edge k. Outputs reflect it after edge k.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs.
- First decrement after start or resume occurs TICK_DIV edges after the starting edge. Subsequent decrements come every TICK_DIV edges.
- Final decrement to 00:00 and the change to state=DONE (heaterOn=0, done=1) appear on the same edge.
- Reset asserted mid-cook: on the next edge all outputs return to reset values. No tick is applied.

## Test plan
- Reset, then pushButton pulses with in=1, 2, 13, 5 → digits read 01:25 (13 ignored), state=IDLE, heaterOn=0.
- TICK_DIV=4, time 00:02, onOff pulse → state=COOK. 00:01 appears 4 edges later. 00:00 with done=1, heaterOn=0, state=DONE appears 8 edges after start.
- Time 01:00 in COOK, one tick → 00:59. Time 10:00 in COOK, one tick → 09:59.
- COOK at 00:05, onOff pulse → PAUSE. Time holds for 20 cycles. onOff again → COOK, next decrement 4 edges later. Then pause and press pushButton → 00:00, IDLE.
- onOff pulse with time 00:00 → stays IDLE. Both buttons rising in the same cycle in IDLE with time 00:03 → COOK, digits unchanged.
- Reset asserted mid-COOK at 00:07 → next edge: IDLE, 00:00, heaterOn=0, done=0. DONE followed by a pushButton pulse → IDLE.
